// File: rtl/ahb_lite_mem_responder.sv
// AHB-Lite slave memory model: per-transfer wait states, byte-lane writes by HSIZE,
// and a two-cycle ERROR response for illegal or windowed addresses.
module ahb_lite_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned WAIT_W     = 4
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [DATA_WIDTH-1:0] hrdata,
  input  logic [WAIT_W-1:0]     cfg_wait,
  input  logic [ADDR_WIDTH-1:0] err_lo,
  input  logic [ADDR_WIDTH-1:0] err_hi,
  input  logic                  err_en
);

  localparam int unsigned NBytes = DATA_WIDTH / 8;
  localparam int unsigned OffW   = $clog2(NBytes);
  localparam int unsigned IdxW   = $clog2(DEPTH);
  localparam int unsigned LoW    = OffW + IdxW;

  typedef enum logic [1:0] {StIdle, StData, StErr1, StErr2} state_e;

  state_e                state_q, state_d;
  logic [LoW-1:0]        addr_q, addr_d;
  logic                  write_q, write_d;
  logic [2:0]            size_q, size_d;
  logic [WAIT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  complete, can_accept, accept, req_err, wr_en;
  logic [IdxW-1:0]       wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0] wr_word, rd_word;
  int unsigned           lane_off, span;
  logic                  unused_htrans;

  assign unused_htrans = htrans[0];

  assign complete   = (state_q == StData) && (cnt_q == '0);
  assign can_accept = (state_q == StIdle) || complete || (state_q == StErr2);
  assign accept     = hsel && hready && htrans[1] && can_accept;

  always_comb begin
    req_err = 1'b0;
    if (hsize > 3'(OffW)) req_err = 1'b1;
    if ((haddr & ~({ADDR_WIDTH{1'b1}} << hsize)) != '0) req_err = 1'b1;
    if (err_en && (haddr >= err_lo) && (haddr <= err_hi)) req_err = 1'b1;
  end

  // Merged write word doubles as the forwarding source for a pipelined read (write-first).
  always_comb begin
    wr_idx   = addr_q[OffW +: IdxW];
    wr_en    = complete && write_q;
    lane_off = 32'(addr_q) & (NBytes - 1);
    span     = 32'd1 << size_q;
    wr_word  = mem_q[wr_idx];
    for (int unsigned b = 0; b < NBytes; b++) begin
      if ((b >= lane_off) && (b < lane_off + span)) wr_word[8*b +: 8] = hwdata[8*b +: 8];
    end
    rd_idx  = accept ? haddr[OffW +: IdxW] : addr_q[OffW +: IdxW];
    rd_word = (wr_en && (wr_idx == rd_idx)) ? wr_word : mem_q[rd_idx];
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= '0;
      cnt_q    <= '0;
      hrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      size_q   <= size_d;
      cnt_q    <= cnt_d;
      hrdata_q <= hrdata_d;
    end
  end

  always_ff @(posedge hclk) begin
    if (wr_en) mem_q[wr_idx] <= wr_word;
  end

  // Read data is loaded on the edge that starts the completing data-phase cycle.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    write_d  = write_q;
    size_d   = size_q;
    cnt_d    = cnt_q;
    hrdata_d = '0;
    if (accept) begin
      addr_d  = haddr[LoW-1:0];
      write_d = hwrite;
      size_d  = hsize;
      cnt_d   = cfg_wait;
      state_d = req_err ? StErr1 : StData;
      if (!req_err && !hwrite && (cfg_wait == '0)) hrdata_d = rd_word;
    end else begin
      unique case (state_q)
        StData: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            if ((cnt_q == WAIT_W'(1)) && !write_q) hrdata_d = rd_word;
          end else begin
            state_d = StIdle;
          end
        end
        StErr1:  state_d = StErr2;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    hreadyout = 1'b1;
    hresp     = 1'b0;
    unique case (state_q)
      StData:  hreadyout = (cnt_q == '0);
      StErr1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
      end
      StErr2:  hresp = 1'b1;
      default: ;
    endcase
  end

  assign hrdata = hrdata_q;

endmodule

// File: tb/tb_ahb_lite_mem_responder.sv
// Randomized bench for ahb_lite_mem_responder against a byte-array transaction model.
module tb_ahb_lite_mem_responder;

  localparam int unsigned AW        = 32;
  localparam int unsigned DW        = 32;
  localparam int unsigned DEPTH     = 256;
  localparam int unsigned WW        = 4;
  localparam int unsigned MEM_BYTES = DEPTH * DW / 8;
  localparam logic [31:0] ERR_LO    = 32'h100;
  localparam logic [31:0] ERR_HI    = 32'h1FF;

  logic          hclk = 1'b0;
  logic          hresetn = 1'b0;
  logic          hsel = 1'b0;
  logic [AW-1:0] haddr = '0;
  logic [1:0]    htrans = 2'b00;
  logic          hwrite = 1'b0;
  logic [2:0]    hsize = 3'd0;
  logic [DW-1:0] hwdata = '0;
  logic          hready;
  logic          hreadyout;
  logic          hresp;
  logic [DW-1:0] hrdata;
  logic [WW-1:0] cfg_wait = '0;
  logic [AW-1:0] err_lo = ERR_LO;
  logic [AW-1:0] err_hi = ERR_HI;
  logic          err_en = 1'b0;
  logic          stall = 1'b0;

  assign hready = hreadyout & ~stall;

  always #5 hclk = ~hclk;

  ahb_lite_mem_responder #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .WAIT_W    (WW)
  ) u_dut (
    .hclk     (hclk),
    .hresetn  (hresetn),
    .hsel     (hsel),
    .haddr    (haddr),
    .htrans   (htrans),
    .hwrite   (hwrite),
    .hsize    (hsize),
    .hwdata   (hwdata),
    .hready   (hready),
    .hreadyout(hreadyout),
    .hresp    (hresp),
    .hrdata   (hrdata),
    .cfg_wait (cfg_wait),
    .err_lo   (err_lo),
    .err_hi   (err_hi),
    .err_en   (err_en)
  );

  typedef struct {
    logic [31:0] addr;
    bit          wr;
    logic [2:0]  size;
    logic [31:0] wdata;
    int unsigned wt;
    bit          en;
    bit          tight;
  } xfer_t;

  xfer_t      q[$];
  logic [7:0] mref [MEM_BYTES];
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_err(input xfer_t x);
    return (x.size > 3'd2) || ((x.addr % (32'd1 << x.size)) != 0) ||
           (x.en && (x.addr >= ERR_LO) && (x.addr <= ERR_HI));
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] addr);
    int unsigned base;
    base = (addr % MEM_BYTES) & ~32'd3;
    return {mref[base+3], mref[base+2], mref[base+1], mref[base]};
  endfunction

  function automatic void ref_write(input xfer_t x);
    int unsigned a;
    a = x.addr % MEM_BYTES;
    for (int i = 0; i < (1 << x.size); i++) mref[a+i] = x.wdata[8*((a%4)+i) +: 8];
  endfunction

  task automatic push(input logic [31:0] addr, input bit wr, input logic [2:0] size,
                      input logic [31:0] wdata, input int unsigned wt, input bit en,
                      input bit tight);
    xfer_t x;
    x.addr = addr; x.wr = wr; x.size = size; x.wdata = wdata;
    x.wt = wt; x.en = en; x.tight = tight;
    q.push_back(x);
  endtask

  task automatic drive_idle();
    case ($urandom % 4)
      0:       begin hsel = 1'b0; htrans = 2'b10; stall = 1'b0; end
      1:       begin hsel = 1'b1; htrans = 2'b00; stall = 1'b0; end
      2:       begin hsel = 1'b1; htrans = 2'b01; stall = 1'b0; end
      default: begin hsel = 1'b1; htrans = 2'b10; stall = 1'b1; end
    endcase
    haddr = 32'h10; hwrite = 1'b1; hsize = 3'd2; err_en = 1'b0;
    cfg_wait = WW'($urandom);
  endtask

  // Pipelined master: the next address phase overlaps the completing data phase.
  task automatic run_queue();
    xfer_t       cur, nxt, x;
    bit          cur_v, nxt_v, done, err;
    int unsigned k, cyc;
    logic        exp_rdy, exp_resp;
    logic [31:0] exp_data;
    cur_v = 0; nxt_v = 0; k = 0; cyc = 0;
    forever begin
      @(posedge hclk); #1;
      cyc++;
      if (nxt_v) begin
        cur = nxt; cur_v = 1; nxt_v = 0; k = 0;
        hwdata = cur.wdata;
      end
      done = 1;
      if (cur_v) begin
        err = is_err(cur);
        if (err) begin
          exp_rdy = (k == 1); exp_resp = 1'b1; exp_data = '0;
        end else begin
          exp_rdy = (k == cur.wt); exp_resp = 1'b0;
          exp_data = (exp_rdy && !cur.wr) ? ref_read(cur.addr) : 32'h0;
        end
        done = exp_rdy;
        check_eq("data_hreadyout", hreadyout, exp_rdy);
        check_eq("data_hresp", hresp, exp_resp);
        check_eq("data_hrdata", hrdata, exp_data);
        if (done) begin
          if (!err && cur.wr) ref_write(cur);
          cur_v = 0;
        end else begin
          k++;
        end
      end else begin
        check_eq("idle_hreadyout", hreadyout, 1);
        check_eq("idle_hresp", hresp, 0);
        check_eq("idle_hrdata", hrdata, 0);
      end
      if (done) begin
        if (q.size() == 0) begin
          drive_idle();
          break;
        end else if (!q[0].tight && ($urandom % 4 == 0)) begin
          drive_idle();
        end else begin
          x = q.pop_front();
          hsel = 1'b1; htrans = ($urandom % 2) ? 2'b10 : 2'b11;
          haddr = x.addr; hwrite = x.wr; hsize = x.size;
          cfg_wait = WW'(x.wt); err_en = x.en; stall = 1'b0;
          nxt = x; nxt_v = 1;
        end
      end else begin
        cfg_wait = WW'($urandom);
      end
      if (cyc > 20000) begin
        check_eq("queue_drained", 64'(q.size()), 0);
        break;
      end
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  sz;
    for (int i = 0; i < MEM_BYTES; i++) mref[i] = 8'h00;
    repeat (2) @(posedge hclk);
    #1;
    check_eq("reset_hreadyout", hreadyout, 1);
    check_eq("reset_hresp", hresp, 0);
    check_eq("reset_hrdata", hrdata, 0);
    hresetn = 1'b1;

    for (int i = 0; i < DEPTH; i++) push(32'(i * 4), 1, 3'd2, 32'h0, 0, 0, 0);
    run_queue();

    push(32'h10, 1, 3'd2, 32'hDEADBEEF, 0, 0, 0);
    push(32'h10, 0, 3'd2, 32'h0, 0, 0, 1);
    push(32'h10, 0, 3'd2, 32'h0, 3, 0, 0);
    push(32'h10, 1, 3'd2, 32'h0, 0, 0, 0);
    push(32'h13, 1, 3'd0, {4{8'hAB}}, 0, 0, 1);
    push(32'h10, 1, 3'd1, {2{16'h1234}}, 0, 0, 1);
    push(32'h10, 0, 3'd2, 32'h0, 0, 0, 1);
    push(32'h104, 1, 3'd2, 32'h55, 0, 1, 0);
    push(32'h104, 0, 3'd2, 32'h0, 0, 0, 1);
    push(32'h100, 0, 3'd2, 32'h0, 2, 1, 1);
    push(32'h02, 0, 3'd2, 32'h0, 0, 0, 0);
    push(32'h00, 0, 3'd3, 32'h0, 0, 0, 1);
    push(32'h02, 1, 3'd2, 32'hFFFFFFFF, 1, 0, 1);
    push(32'h00, 0, 3'd2, 32'h0, 0, 0, 1);
    push(32'h400, 1, 3'd2, 32'h11, 0, 0, 0);
    push(32'h000, 0, 3'd2, 32'h0, 0, 0, 1);
    push(32'h20, 1, 3'd2, 32'h12345678, 0, 0, 0);
    push(32'h20, 0, 3'd2, 32'h0, 0, 0, 1);
    run_queue();

    for (int i = 0; i < 400; i++) begin
      sz = 3'($urandom % 4);
      if ($urandom % 8 == 0) a = ERR_LO + ($urandom % 256);
      else a = (($urandom % 16) * 4) + ($urandom % 4) + (($urandom % 3) * 1024);
      if ($urandom % 3 != 0) a = a & ~((32'd1 << sz) - 1);
      push(a, bit'($urandom % 2), sz, $urandom, ($urandom % 2) ? 0 : ($urandom % 4),
           bit'($urandom % 2), bit'($urandom % 2));
    end
    run_queue();

    // Reset in the middle of a 3-wait write must drop the write.
    @(posedge hclk); #1;
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h20; hwrite = 1'b1; hsize = 3'd2;
    cfg_wait = WW'(3); err_en = 1'b0; stall = 1'b0;
    @(posedge hclk); #1;
    htrans = 2'b00; hwdata = 32'hCAFEF00D;
    check_eq("rst_wait_hreadyout", hreadyout, 0);
    @(posedge hclk); #1;
    hresetn = 1'b0;
    #1;
    check_eq("rst_async_hreadyout", hreadyout, 1);
    check_eq("rst_async_hresp", hresp, 0);
    check_eq("rst_async_hrdata", hrdata, 0);
    @(posedge hclk); #1;
    hresetn = 1'b1;
    push(32'h20, 0, 3'd2, 32'h0, 0, 0, 1);
    push(32'h420, 0, 3'd2, 32'h0, 1, 0, 1);
    run_queue();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
